// File: rtl/cv32e40px_x_result_buffer.sv
// -----------------------------------------------------------------------------
// cv32e40px_x_result_buffer
//
// Purpose:
//   In-order result buffer on the coprocessor side of the CORE-V-XIF result
//   interface. The buffer allocates one entry per accepted offload and collects
//   execution results, which may arrive out of order, by id. It tracks
//   commit/kill per entry and returns results to the core strictly in issue
//   order. Killed entries are retired silently once their result has arrived.
//
// Configuration macro:
//   CV32E40PX_XRB_BYPASS_EN - when defined, a result that targets a committed
//   head entry is forwarded combinationally to the result port in the same
//   cycle. When undefined, there is no combinational path from ex_* to
//   result_*.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   alloc_valid_i/ready_o   issue-accept handshake (ready = buffer not full)
//   alloc_id_i, alloc_wb_i  id and writeback flag of the accepted instruction
//   commit_valid_i, commit_id_i, commit_kill_i   commit/kill strobe
//   ex_valid_i/ready_o      execution result handshake (ready = id pending)
//   ex_id_i, ex_data_i, ex_rd_i                  execution result fields
//   result_valid_o/ready_i  result handshake towards the core
//   result_id_o, result_data_o, result_rd_o, result_we_o   head entry fields
//   protocol_err_o          sticky protocol violation flag
// -----------------------------------------------------------------------------
module cv32e40px_x_result_buffer #(
  parameter int DEPTH      = 4,
  parameter int ID_WIDTH   = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  alloc_valid_i,
  output logic                  alloc_ready_o,
  input  logic [ID_WIDTH-1:0]   alloc_id_i,
  input  logic                  alloc_wb_i,
  input  logic                  commit_valid_i,
  input  logic [ID_WIDTH-1:0]   commit_id_i,
  input  logic                  commit_kill_i,
  input  logic                  ex_valid_i,
  output logic                  ex_ready_o,
  input  logic [ID_WIDTH-1:0]   ex_id_i,
  input  logic [DATA_WIDTH-1:0] ex_data_i,
  input  logic [4:0]            ex_rd_i,
  output logic                  result_valid_o,
  input  logic                  result_ready_i,
  output logic [ID_WIDTH-1:0]   result_id_o,
  output logic [DATA_WIDTH-1:0] result_data_o,
  output logic [4:0]            result_rd_o,
  output logic                  result_we_o,
  output logic                  protocol_err_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Entry storage: per-entry flags as packed vectors, payload as arrays.
  logic [DEPTH-1:0]      r_vld;
  logic [DEPTH-1:0]      r_wb;
  logic [DEPTH-1:0]      r_res;
  logic [DEPTH-1:0]      r_cmt;
  logic [DEPTH-1:0]      r_kil;
  logic [ID_WIDTH-1:0]   r_id   [DEPTH];
  logic [DATA_WIDTH-1:0] r_data [DEPTH];
  logic [4:0]            r_rd   [DEPTH];

  logic [PTR_W-1:0]      r_rd_ptr;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [CNT_W-1:0]      r_count;
  logic                  r_err;

  logic                  w_cmt_found;
  logic [PTR_W-1:0]      w_cmt_idx;
  logic                  w_cmt_ok;
  logic                  w_ex_hit;
  logic [PTR_W-1:0]      w_ex_idx;
  logic                  w_ex_wr;
  logic                  w_head_ready;
  logic                  w_stored_valid;
  logic                  w_byp;
  logic                  w_kill_pop;
  logic                  w_pop;
  logic                  w_alloc;
  logic                  w_err_set;

  // Commit target: scan from the head for the oldest live, unresolved entry.
  always_comb begin
    w_cmt_found = 1'b0;
    w_cmt_idx   = r_rd_ptr;
    for (int i = 0; i < DEPTH; i++) begin
      if (!w_cmt_found && r_vld[r_rd_ptr + PTR_W'(i)] &&
          !r_cmt[r_rd_ptr + PTR_W'(i)] && !r_kil[r_rd_ptr + PTR_W'(i)]) begin
        w_cmt_found = 1'b1;
        w_cmt_idx   = r_rd_ptr + PTR_W'(i);
      end else begin
        w_cmt_found = w_cmt_found;
      end
    end
  end

  // Result CAM: ids are unique among valid entries, so at most one entry hits.
  always_comb begin
    w_ex_hit = 1'b0;
    w_ex_idx = {PTR_W{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      if (r_vld[i] && !r_res[i] && (r_id[i] == ex_id_i)) begin
        w_ex_hit = 1'b1;
        w_ex_idx = PTR_W'(i);
      end else begin
        w_ex_hit = w_ex_hit;
      end
    end
  end

  // Head status and the optional same-cycle forward of a result to the head.
  always_comb begin
    w_head_ready   = r_vld[r_rd_ptr] & r_cmt[r_rd_ptr] & ~r_kil[r_rd_ptr];
    w_stored_valid = w_head_ready & r_res[r_rd_ptr];
    w_kill_pop     = r_vld[r_rd_ptr] & r_kil[r_rd_ptr] & r_res[r_rd_ptr];
`ifdef CV32E40PX_XRB_BYPASS_EN
    w_byp          = w_head_ready & ~r_res[r_rd_ptr] & ex_valid_i &
                     (ex_id_i == r_id[r_rd_ptr]);
`else
    w_byp          = 1'b0;
`endif
  end

  // Result port fields; the forwarded mux exists only in the bypass build.
  always_comb begin
    result_valid_o = w_stored_valid | w_byp;
    result_id_o    = r_id[r_rd_ptr];
    result_we_o    = r_wb[r_rd_ptr];
`ifdef CV32E40PX_XRB_BYPASS_EN
    if (w_byp) begin
      result_data_o = ex_data_i;
      result_rd_o   = ex_rd_i;
    end else begin
      result_data_o = r_data[r_rd_ptr];
      result_rd_o   = r_rd[r_rd_ptr];
    end
`else
    result_data_o = r_data[r_rd_ptr];
    result_rd_o   = r_rd[r_rd_ptr];
`endif
  end

  // Handshake qualifiers and error detection.
  always_comb begin
    alloc_ready_o  = (r_count != CNT_W'(DEPTH));
    ex_ready_o     = w_ex_hit;
    protocol_err_o = r_err;
    w_alloc        = alloc_valid_i & alloc_ready_o;
    w_pop          = (result_valid_o & result_ready_i) | w_kill_pop;
    // A forwarded result that is accepted right away never needs storing.
    w_ex_wr        = ex_valid_i & w_ex_hit & ~(w_byp & result_ready_i);
    w_cmt_ok       = commit_valid_i & w_cmt_found & (r_id[w_cmt_idx] == commit_id_i);
    w_err_set      = (commit_valid_i & ~w_cmt_ok) | (ex_valid_i & ~w_ex_hit);
  end

  // Entry state, pointers, occupancy and the sticky error flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_vld    <= {DEPTH{1'b0}};
      r_wb     <= {DEPTH{1'b0}};
      r_res    <= {DEPTH{1'b0}};
      r_cmt    <= {DEPTH{1'b0}};
      r_kil    <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        r_id[i]   <= {ID_WIDTH{1'b0}};
        r_data[i] <= {DATA_WIDTH{1'b0}};
        r_rd[i]   <= 5'd0;
      end
      r_rd_ptr <= {PTR_W{1'b0}};
      r_wr_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
      r_err    <= 1'b0;
    end else begin
      // Alloc, commit, ex-write and pop never touch the same entry in one
      // cycle: alloc uses a free slot, and commit/ex cannot target a
      // popping head because that head is already resolved.
      if (w_ex_wr) begin
        r_res[w_ex_idx]  <= 1'b1;
        r_data[w_ex_idx] <= ex_data_i;
        r_rd[w_ex_idx]   <= ex_rd_i;
      end
      if (w_cmt_ok) begin
        if (commit_kill_i) begin
          r_kil[w_cmt_idx] <= 1'b1;
        end else begin
          r_cmt[w_cmt_idx] <= 1'b1;
        end
      end
      if (w_alloc) begin
        r_vld[r_wr_ptr] <= 1'b1;
        r_id[r_wr_ptr]  <= alloc_id_i;
        r_wb[r_wr_ptr]  <= alloc_wb_i;
        r_res[r_wr_ptr] <= 1'b0;
        r_cmt[r_wr_ptr] <= 1'b0;
        r_kil[r_wr_ptr] <= 1'b0;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_vld[r_rd_ptr] <= 1'b0;
        r_rd_ptr        <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_alloc, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_err_set) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cv32e40px_x_result_buffer.sv
// -----------------------------------------------------------------------------
// tb_cv32e40px_x_result_buffer
//
// Purpose:
//   Self-checking bench for cv32e40px_x_result_buffer. Expected results are
//   pushed to a scoreboard queue in issue order when an instruction is
//   allocated (killed ones are not pushed); the monitor compares the head of
//   the queue with the result port whenever result_valid_o is high and pops it
//   on a completed handshake. Define CV32E40PX_XRB_BYPASS_EN for both files to
//   exercise the same-cycle forwarding build.
// -----------------------------------------------------------------------------
module tb_cv32e40px_x_result_buffer;

`ifdef CV32E40PX_XRB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        alloc_valid_i;
  logic        alloc_ready_o;
  logic [3:0]  alloc_id_i;
  logic        alloc_wb_i;
  logic        commit_valid_i;
  logic [3:0]  commit_id_i;
  logic        commit_kill_i;
  logic        ex_valid_i;
  logic        ex_ready_o;
  logic [3:0]  ex_id_i;
  logic [31:0] ex_data_i;
  logic [4:0]  ex_rd_i;
  logic        result_valid_o;
  logic        result_ready_i;
  logic [3:0]  result_id_o;
  logic [31:0] result_data_o;
  logic [4:0]  result_rd_o;
  logic        result_we_o;
  logic        protocol_err_o;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  cv32e40px_x_result_buffer #(
    .DEPTH(4), .ID_WIDTH(4), .DATA_WIDTH(32)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .alloc_valid_i(alloc_valid_i), .alloc_ready_o(alloc_ready_o),
    .alloc_id_i(alloc_id_i), .alloc_wb_i(alloc_wb_i),
    .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i),
    .commit_kill_i(commit_kill_i),
    .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o), .ex_id_i(ex_id_i),
    .ex_data_i(ex_data_i), .ex_rd_i(ex_rd_i),
    .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
    .result_id_o(result_id_o), .result_data_o(result_data_o),
    .result_rd_o(result_rd_o), .result_we_o(result_we_o),
    .protocol_err_o(protocol_err_o)
  );

  // Free-running clock, period 10.
  always #5 clk_i = ~clk_i;

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, required completion");
    $fatal(1);
  end

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Compare the port against the scoreboard head; pop on a handshake.
  task automatic monitor();
    if (result_valid_o) begin
      if (sb.size() == 0) begin
        check_value("spurious_valid", 64'(result_valid_o), 64'd0);
      end else begin
        check_value("res_id",   64'(result_id_o),   64'(sb[0].id));
        check_value("res_data", 64'(result_data_o), 64'(sb[0].data));
        check_value("res_rd",   64'(result_rd_o),   64'(sb[0].rd));
        check_value("res_we",   64'(result_we_o),   64'(sb[0].we));
        if (result_ready_i) void'(sb.pop_front());
      end
    end
  endtask

  // Inputs are driven 1 time unit after posedge and sampled 2 units later.
  task automatic finish_cycle();
    monitor();
    @(posedge clk_i);
    #1;
    alloc_valid_i  = 1'b0;
    commit_valid_i = 1'b0;
    commit_kill_i  = 1'b0;
    ex_valid_i     = 1'b0;
  endtask

  task automatic idle(input int exp_v);
    #2;
    if (exp_v >= 0) check_value("rvalid", 64'(result_valid_o), 64'(exp_v));
    finish_cycle();
  endtask

  task automatic do_reset();
    rst_i          = 1'b1;
    alloc_valid_i  = 1'b0;
    alloc_id_i     = 4'd0;
    alloc_wb_i     = 1'b0;
    commit_valid_i = 1'b0;
    commit_id_i    = 4'd0;
    commit_kill_i  = 1'b0;
    ex_valid_i     = 1'b0;
    ex_id_i        = 4'd0;
    ex_data_i      = 32'd0;
    ex_rd_i        = 5'd0;
    result_ready_i = 1'b1;
    repeat (2) begin
      @(posedge clk_i);
      #1;
    end
    rst_i = 1'b0;
    sb.delete();
  endtask

  task automatic do_alloc(input logic [3:0] id, input logic wb, input logic [31:0] data,
                          input logic [4:0] rd, input bit killed);
    exp_t e;
    alloc_valid_i = 1'b1;
    alloc_id_i    = id;
    alloc_wb_i    = wb;
    #2;
    check_value("alloc_ready", 64'(alloc_ready_o), 64'd1);
    if (!killed) begin
      e.id = id; e.data = data; e.rd = rd; e.we = wb;
      sb.push_back(e);
    end
    finish_cycle();
  endtask

  task automatic do_commit(input logic [3:0] id, input logic kill);
    commit_valid_i = 1'b1;
    commit_id_i    = id;
    commit_kill_i  = kill;
    #2;
    finish_cycle();
  endtask

  task automatic do_ex(input logic [3:0] id, input logic [31:0] data, input logic [4:0] rd,
                       input logic exp_ready, input int exp_v);
    ex_valid_i = 1'b1;
    ex_id_i    = id;
    ex_data_i  = data;
    ex_rd_i    = rd;
    #2;
    check_value("ex_ready", 64'(ex_ready_o), 64'(exp_ready));
    if (exp_v >= 0) check_value("rvalid_ex", 64'(result_valid_o), 64'(exp_v));
    finish_cycle();
  endtask

  task automatic drain();
    for (int k = 0; k < 30 && sb.size() > 0; k++) idle(-1);
    check_value("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    do_reset();

    // Reset state.
    #2;
    check_value("rst_rvalid", 64'(result_valid_o), 64'd0);
    check_value("rst_aready", 64'(alloc_ready_o), 64'd1);
    check_value("rst_exready", 64'(ex_ready_o), 64'd0);
    check_value("rst_err", 64'(protocol_err_o), 64'd0);
    check_value("rst_data", 64'(result_data_o), 64'd0);
    check_value("rst_id", 64'(result_id_o), 64'd0);
    check_value("rst_rd", 64'(result_rd_o), 64'd0);
    check_value("rst_we", 64'(result_we_o), 64'd0);
    finish_cycle();

    // In order: result appears one cycle after ex (same cycle with forwarding).
    do_alloc(4'd3, 1'b1, 32'hA5A5_0001, 5'd7, 1'b0);
    do_alloc(4'd5, 1'b1, 32'h5555_0005, 5'd9, 1'b0);
    do_commit(4'd3, 1'b0);
    do_commit(4'd5, 1'b0);
    do_ex(4'd3, 32'hA5A5_0001, 5'd7, 1'b1, BYP ? 1 : 0);
    idle(BYP ? 0 : 1);
    do_ex(4'd5, 32'h5555_0005, 5'd9, 1'b1, -1);
    drain();

    // Out-of-order execution: nothing leaves until the oldest completes.
    do_alloc(4'd1, 1'b1, 32'h0000_0011, 5'd1, 1'b0);
    do_alloc(4'd2, 1'b0, 32'h0000_0022, 5'd2, 1'b0);
    do_commit(4'd1, 1'b0);
    do_commit(4'd2, 1'b0);
    do_ex(4'd2, 32'h0000_0022, 5'd2, 1'b1, 0);
    idle(0);
    do_ex(4'd1, 32'h0000_0011, 5'd1, 1'b1, BYP ? 1 : 0);
    idle(1);
    drain();

    // Kill: id 4 retires silently, id 6 follows.
    do_alloc(4'd4, 1'b1, 32'hDEAD_0004, 5'd4, 1'b1);
    do_alloc(4'd6, 1'b1, 32'h0000_0066, 5'd6, 1'b0);
    do_commit(4'd4, 1'b1);
    do_commit(4'd6, 1'b0);
    do_ex(4'd6, 32'h0000_0066, 5'd6, 1'b1, 0);
    idle(0);
    do_ex(4'd4, 32'hDEAD_0004, 5'd4, 1'b1, 0);
    idle(0);
    idle(1);
    drain();

    // Full and backpressure.
    for (int i = 0; i < 4; i++)
      do_alloc(4'(8 + i), 1'(i), 32'h8000_0000 + 32'(i), 5'(10 + i), 1'b0);
    #2;
    check_value("full_aready", 64'(alloc_ready_o), 64'd0);
    finish_cycle();
    for (int i = 0; i < 4; i++) do_commit(4'(8 + i), 1'b0);
    result_ready_i = 1'b0;
    do_ex(4'd8, 32'h8000_0000, 5'd10, 1'b1, -1);
    for (int k = 0; k < 5; k++) begin
      #2;
      check_value("hold_rvalid", 64'(result_valid_o), 64'd1);
      check_value("hold_aready", 64'(alloc_ready_o), 64'd0);
      finish_cycle();
    end
    result_ready_i = 1'b1;
    #2;
    check_value("pop_cycle_aready", 64'(alloc_ready_o), 64'd0);
    finish_cycle();
    #2;
    check_value("after_pop_aready", 64'(alloc_ready_o), 64'd1);
    finish_cycle();
    for (int i = 1; i < 4; i++)
      do_ex(4'(8 + i), 32'h8000_0000 + 32'(i), 5'(10 + i), 1'b1, -1);
    drain();

    // Errors: unmatched ex after a mid-operation reset flush.
    do_alloc(4'd7, 1'b1, 32'h0000_0077, 5'd7, 1'b0);
    do_reset();
    #2;
    check_value("flush_aready", 64'(alloc_ready_o), 64'd1);
    check_value("flush_err", 64'(protocol_err_o), 64'd0);
    finish_cycle();
    do_ex(4'd7, 32'h0000_0077, 5'd7, 1'b0, 0);
    #2;
    check_value("ex_nomatch_err", 64'(protocol_err_o), 64'd1);
    finish_cycle();
    do_reset();
    #2;
    check_value("err_cleared", 64'(protocol_err_o), 64'd0);
    finish_cycle();

    // Errors: out-of-order commit id leaves entries untouched.
    do_alloc(4'd8, 1'b1, 32'h0808_0808, 5'd8, 1'b0);
    do_alloc(4'd9, 1'b1, 32'h0909_0909, 5'd9, 1'b0);
    #2;
    check_value("pre_cmt_err", 64'(protocol_err_o), 64'd0);
    finish_cycle();
    do_commit(4'd9, 1'b0);
    #2;
    check_value("bad_cmt_err", 64'(protocol_err_o), 64'd1);
    finish_cycle();
    do_commit(4'd8, 1'b0);
    do_commit(4'd9, 1'b0);
    do_ex(4'd9, 32'h0909_0909, 5'd9, 1'b1, 0);
    do_ex(4'd8, 32'h0808_0808, 5'd8, 1'b1, -1);
    drain();
    #2;
    check_value("err_sticky", 64'(protocol_err_o), 64'd1);
    finish_cycle();

`ifdef CV32E40PX_XRB_BYPASS_EN
    // Forwarding: committed head completes and pops in the ex cycle.
    do_reset();
    for (int i = 0; i < 4; i++)
      do_alloc(4'(12 + i), 1'b1, 32'hC0DE_0000 + 32'(i), 5'(20 + i), 1'b0);
    do_commit(4'd12, 1'b0);
    ex_valid_i = 1'b1;
    ex_id_i    = 4'd12;
    ex_data_i  = 32'hC0DE_0000;
    ex_rd_i    = 5'd20;
    #2;
    check_value("byp_rvalid", 64'(result_valid_o), 64'd1);
    check_value("byp_aready_full", 64'(alloc_ready_o), 64'd0);
    finish_cycle();
    #2;
    check_value("byp_aready_next", 64'(alloc_ready_o), 64'd1);
    check_value("byp_popped", 64'(sb.size()), 64'd3);
    finish_cycle();
    for (int i = 1; i < 4; i++) do_commit(4'(12 + i), 1'b0);
    for (int i = 1; i < 4; i++)
      do_ex(4'(12 + i), 32'hC0DE_0000 + 32'(i), 5'(20 + i), 1'b1, -1);
    drain();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
